// File: rtl/div_meas_pkg.sv
// ============================================================================
// Module      : div_meas_pkg
// Description : Shared state encoding and default sizes for divider meters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_meas_pkg;

    localparam int c_cnt_w       = 16;
    localparam int c_sync_stages = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sig_sync_edge.sv
// ============================================================================
// Module      : sig_sync_edge
// Description : Multi-flop synchronizer for an async level plus edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sig_d;
    logic                   w_sig_s;

    assign w_sig_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_sig_d <= w_sig_s;
        end
    end

    assign o_rise = w_sig_s & ~r_sig_d;
    assign o_fall = ~w_sig_s & r_sig_d;

endmodule

`default_nettype wire

// File: rtl/div_period_meter.sv
// ============================================================================
// Module      : div_period_meter
// Description : Measures period and high time of a slow divided clock in clk
//               cycles, with a valid strobe and a no-toggle timeout strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_period_meter
    import div_meas_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w,
    parameter int SYNC_STAGES = c_sync_stages
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             w_rise;
    logic             w_fall;
    state_t           r_state;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic             r_hi_act;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_meas_valid;
    logic             r_timeout;
    logic             r_busy;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (sig_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // In ARMED, r_per_cnt doubles as the saturation counter for the first rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_hi_act     <= 1'b0;
            r_period     <= '0;
            r_high       <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            if (!en) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_hi_act <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_ARMED;
                        r_busy    <= 1'b1;
                        r_per_cnt <= '0;
                    end
                    ST_ARMED: begin
                        if (w_rise) begin
                            r_state   <= ST_MEASURE;
                            r_per_cnt <= c_cnt_one;
                            r_hi_cnt  <= c_cnt_one;
                            r_hi_act  <= 1'b1;
                        end else if (r_per_cnt == c_cnt_max) begin
                            r_timeout <= 1'b1;
                            r_per_cnt <= '0;
                        end else begin
                            r_per_cnt <= r_per_cnt + c_cnt_one;
                        end
                    end
                    ST_MEASURE: begin
                        // Rise has priority over saturation: a full-scale period is still reported.
                        if (w_rise) begin
                            r_period     <= r_per_cnt;
                            r_high       <= r_hi_cnt;
                            r_meas_valid <= 1'b1;
                            r_per_cnt    <= c_cnt_one;
                            r_hi_cnt     <= c_cnt_one;
                            r_hi_act     <= 1'b1;
                        end else if (r_per_cnt == c_cnt_max) begin
                            r_state   <= ST_ARMED;
                            r_timeout <= 1'b1;
                            r_per_cnt <= '0;
                            r_hi_act  <= 1'b0;
                        end else begin
                            r_per_cnt <= r_per_cnt + c_cnt_one;
                            if (w_fall) begin
                                r_hi_act <= 1'b0;
                            end else if (r_hi_act) begin
                                r_hi_cnt <= r_hi_cnt + c_cnt_one;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high;
    assign meas_valid = r_meas_valid;
    assign timeout    = r_timeout;
    assign busy       = r_busy;

endmodule

`default_nettype wire
